// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
// Groups the two requester handshakes and the SRAM strobe/address bus used by
// sram_arbiter.
//   master : the requester and SRAM side (drives req/we/ub/lb/addr/wdata,
//            observes ack/rdata/busy and the SRAM strobes)
//   slave  : the arbiter (observes requests, drives acks, rdata, busy, strobes)
// Signals:
//   req0/req1, we0/we1, ub0/ub1, lb0/lb1   per-port request attributes
//   addr0/addr1 [ADDR_W], wdata0/wdata1 [DATA_W]
//   ack0/ack1, rdata [DATA_W], busy        arbiter status back to requesters
//   CE, UB, LB, OE, WE (active-low), ADDR [ADDR_W]  SRAM control
// The bidirectional SRAM data bus is kept as a plain port on the arbiter so
// the resolved net lives at board level alongside the SRAM.
// -----------------------------------------------------------------------------
interface sram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic              ub0;
  logic              ub1;
  logic              lb0;
  logic              lb1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;

  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  logic              CE;
  logic              UB;
  logic              LB;
  logic              OE;
  logic              WE;
  logic [ADDR_W-1:0] ADDR;

  modport master (
    output req0, req1, we0, we1, ub0, ub1, lb0, lb1,
    output addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata, busy,
    input  CE, UB, LB, OE, WE, ADDR
  );

  modport slave (
    input  req0, req1, we0, we1, ub0, ub1, lb0, lb1,
    input  addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata, busy,
    output CE, UB, LB, OE, WE, ADDR
  );
endinterface

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Shares one asynchronous 16-bit SRAM between port 0 (CPU memory path) and
// port 1 (loader / debug). Round-robin arbitration, one transaction at a time,
// IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> DONE -> IDLE.
// Ports:
//   Clk    in     system clock, rising edge
//   Reset  in     asynchronous, active-high
//   bus    slave  requester handshakes, rdata/busy, SRAM strobes and ADDR
//   Data   inout  SRAM bidirectional data bus
// Parameters:
//   ADDR_W, DATA_W  SRAM address / data width
//   WAIT_CYCLES     strobe active width in ACCESS; values below 1 act as 1
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch the winner's request
// SETUP  | address, CE, OE/byte lanes valid; write data driven, WE still high
// ACCESS | WAIT_CYCLES cycles; write pulses WE low; read captured on last edge
// DONE   | strobes released, write data held one more cycle, ack pulses
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  sram_arbiter_if.slave     bus,
  inout  wire  [DATA_W-1:0] Data
);

  localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CNT_W    = $clog2(WAIT_EFF + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;

  logic              rr;         // port that wins when both request
  logic              gnt;        // port owning the current transaction
  logic              lat_we;
  logic              lat_ub;
  logic              lat_lb;
  logic [DATA_W-1:0] lat_wdata;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  cnt;

  logic              win;
  logic              grant;
  logic              last_access;
  logic              drive;

  // Winner selection: a lone requester always wins; on contention the
  // round-robin pointer decides.
  always_comb begin
    win = 1'b0;
    if (bus.req0 && bus.req1) begin
      win = rr;
    end else if (bus.req1) begin
      win = 1'b1;
    end
  end

  assign grant       = (state == IDLE) && (bus.req0 || bus.req1);
  assign last_access = (state == ACCESS) && (cnt == CNT_LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and strobe decode. Strobes decode straight from the state
  // register so an async reset releases them in the same cycle.
  always_comb begin
    state_nx = state;
    bus.CE   = 1'b1;
    bus.UB   = 1'b1;
    bus.LB   = 1'b1;
    bus.OE   = 1'b1;
    bus.WE   = 1'b1;
    bus.ack0 = 1'b0;
    bus.ack1 = 1'b0;
    drive    = 1'b0;

    case (state)
      IDLE: begin
        if (grant) begin
          state_nx = SETUP;
        end
      end
      SETUP: begin
        bus.CE   = 1'b0;
        bus.UB   = ~lat_ub;
        bus.LB   = ~lat_lb;
        bus.OE   = lat_we;
        drive    = lat_we;
        state_nx = ACCESS;
      end
      ACCESS: begin
        bus.CE = 1'b0;
        bus.UB = ~lat_ub;
        bus.LB = ~lat_lb;
        bus.OE = lat_we;
        bus.WE = ~lat_we;
        drive  = lat_we;
        if (last_access) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        // Write data held through DONE so the SRAM sees it after WE rises.
        drive    = lat_we;
        bus.ack0 = ~gnt;
        bus.ack1 = gnt;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rr        <= 1'b0;
      gnt       <= 1'b0;
      lat_we    <= 1'b0;
      lat_ub    <= 1'b0;
      lat_lb    <= 1'b0;
      lat_wdata <= '0;
      addr_q    <= '0;
      rdata_q   <= '0;
      cnt       <= '0;
    end else begin
      if (grant) begin
        gnt       <= win;
        rr        <= ~win;
        lat_we    <= win ? bus.we1    : bus.we0;
        lat_ub    <= win ? bus.ub1    : bus.ub0;
        lat_lb    <= win ? bus.lb1    : bus.lb0;
        lat_wdata <= win ? bus.wdata1 : bus.wdata0;
        addr_q    <= win ? bus.addr1  : bus.addr0;
        cnt       <= CNT_LOAD;
      end
      if (state == ACCESS) begin
        cnt <= cnt - CNT_LAST;
      end
      if (last_access && !lat_we) begin
        rdata_q <= Data;
      end
    end
  end

  assign Data      = drive ? lat_wdata : {DATA_W{1'bz}};
  assign bus.ADDR  = addr_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = (state != IDLE);

endmodule
